// File: rtl/ctrl_fsm_timed.sv
// Control-path sequencer: halt/fetch/load/store/execute/trap with memory-wait timeouts,
// multi-cycle ALU stalls, a latched trap cause, registered memory strobes and a retire counter.
module ctrl_fsm_timed #(
   parameter int TMO_W   = 8,
   parameter int TMO_MAX = 255,
   parameter int RET_W   = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             go,
   input  logic             halt,
   input  logic             instr_alu,
   input  logic             instr_pc,
   input  logic             ld,
   input  logic             st,
   input  logic             wait_instr,
   input  logic             wait_data,
   input  logic             alu_busy,
   input  logic             instr_segv,
   input  logic             data_segv,
   input  logic             invalid_instruction,
   input  logic             trap_ack,
   output logic [4:0]       current_state,
   output logic [2:0]       trap_cause,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             retired,
   output logic [RET_W-1:0] retired_count
);

   typedef enum logic [4:0] {
      S_HALT       = 5'b00000,
      S_READ_INS   = 5'b01000,
      S_DO         = 5'b01001,
      S_WAIT_LOAD  = 5'b01010,
      S_EXEC_WAIT  = 5'b01011,
      S_WAIT_STORE = 5'b01100,
      S_TRAP       = 5'b10000
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

   // Held as plain bits so that an unlisted code can exist and be recovered from.
   logic [4:0]       state_q;
   state_t           next_state;
   logic [2:0]       next_cause;
   logic             tmo_inc;
   logic             tmo_hit;
   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit       = (tmo_cnt == TMO_LIM);
   assign current_state = state_q;
   assign retired       = (state_q == S_DO);

   always_comb begin
      next_state = S_HALT;
      next_cause = trap_cause;
      tmo_inc    = 1'b0;
      case (state_q)
         S_HALT: begin
            next_state = go ? S_READ_INS : S_HALT;
            if (go) next_cause = 3'd0;
         end
         S_READ_INS: begin
            if (instr_segv) begin
               next_state = S_TRAP;
               next_cause = 3'd1;
            end else if (wait_instr) begin
               if (tmo_hit) begin
                  next_state = S_TRAP;
                  next_cause = 3'd4;
               end else begin
                  next_state = S_READ_INS;
                  tmo_inc    = 1'b1;
               end
            end else if (invalid_instruction) begin
               next_state = S_TRAP;
               next_cause = 3'd3;
            end else if (ld) begin
               next_state = S_WAIT_LOAD;
            end else if (st) begin
               next_state = S_WAIT_STORE;
            end else if (instr_alu && alu_busy) begin
               next_state = S_EXEC_WAIT;
            end else if (instr_alu || instr_pc) begin
               next_state = S_DO;
            end else begin
               next_state = S_DO;
            end
         end
         S_WAIT_LOAD, S_WAIT_STORE: begin
            if (data_segv) begin
               next_state = S_TRAP;
               next_cause = 3'd2;
            end else if (wait_data) begin
               if (tmo_hit) begin
                  next_state = S_TRAP;
                  next_cause = 3'd5;
               end else begin
                  next_state = (state_q == S_WAIT_LOAD) ? S_WAIT_LOAD : S_WAIT_STORE;
                  tmo_inc    = 1'b1;
               end
            end else begin
               next_state = S_DO;
            end
         end
         S_EXEC_WAIT: begin
            next_state = alu_busy ? S_EXEC_WAIT : S_DO;
         end
         S_DO: begin
            if (data_segv) begin
               next_state = S_TRAP;
               next_cause = 3'd2;
            end else if (invalid_instruction) begin
               next_state = S_TRAP;
               next_cause = 3'd3;
            end else if (halt) begin
               next_state = S_HALT;
            end else begin
               next_state = S_READ_INS;
            end
         end
         S_TRAP: begin
            next_state = trap_ack ? S_HALT : S_TRAP;
         end
         default: begin
            next_state = S_HALT;
         end
      endcase
   end

   // Strobes fire only on entry to a memory-wait state; the retire count bumps on every DO cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= S_HALT;
         trap_cause    <= 3'd0;
         mem_rd        <= 1'b0;
         mem_wr        <= 1'b0;
         retired_count <= '0;
         tmo_cnt       <= '0;
      end else begin
         state_q    <= next_state;
         trap_cause <= next_cause;
         mem_rd     <= (next_state == S_WAIT_LOAD) && (state_q != S_WAIT_LOAD);
         mem_wr     <= (next_state == S_WAIT_STORE) && (state_q != S_WAIT_STORE);
         if (state_q == S_DO) retired_count <= retired_count + RET_W'(1);
         if (next_state != state_q) begin
            tmo_cnt <= '0;
         end else if (tmo_inc && (tmo_cnt != '1)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ctrl_fsm_timed.sv
// Self-checking bench for ctrl_fsm_timed: a behavioural model pushes expected outputs per driven
// cycle into a scoreboard queue, which is popped and compared after each rising edge.
module tb_ctrl_fsm_timed;

   localparam int TMO_MAX = 4;
   localparam int RET_W   = 16;

   localparam logic [4:0] M_HALT = 5'b00000;
   localparam logic [4:0] M_READ = 5'b01000;
   localparam logic [4:0] M_DO   = 5'b01001;
   localparam logic [4:0] M_WL   = 5'b01010;
   localparam logic [4:0] M_EW   = 5'b01011;
   localparam logic [4:0] M_WS   = 5'b01100;
   localparam logic [4:0] M_TRAP = 5'b10000;

   logic clk = 1'b0;
   logic resetn, go, halt, instr_alu, instr_pc, ld, st, wait_instr, wait_data;
   logic alu_busy, instr_segv, data_segv, invalid_instruction, trap_ack;
   logic [4:0]       current_state;
   logic [2:0]       trap_cause;
   logic             mem_rd, mem_wr, retired;
   logic [RET_W-1:0] retired_count;

   ctrl_fsm_timed #(.TMO_W(8), .TMO_MAX(TMO_MAX), .RET_W(RET_W)) dut (
      .clk(clk), .resetn(resetn), .go(go), .halt(halt), .instr_alu(instr_alu),
      .instr_pc(instr_pc), .ld(ld), .st(st), .wait_instr(wait_instr), .wait_data(wait_data),
      .alu_busy(alu_busy), .instr_segv(instr_segv), .data_segv(data_segv),
      .invalid_instruction(invalid_instruction), .trap_ack(trap_ack),
      .current_state(current_state), .trap_cause(trap_cause), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .retired(retired), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic resetn, go, halt, instr_alu, instr_pc, ld, st, wait_instr, wait_data;
      logic alu_busy, instr_segv, data_segv, invalid_instruction, trap_ack;
   } stim_t;

   typedef struct {
      logic [4:0]       state;
      logic [2:0]       cause;
      logic             rd, wr, ret;
      logic [RET_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   logic [4:0]       m_state = M_HALT;
   logic [2:0]       m_cause = 3'd0;
   logic [RET_W-1:0] m_cnt   = '0;
   int               m_tmo   = 0;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.resetn = 1'b1;
      return s;
   endfunction

   // Reference behaviour: one call per clock edge, returns the outputs expected after that edge.
   task automatic modelStep(input stim_t s);
      logic [4:0] ns;
      logic [2:0] nc;
      logic       nrd, nwr;
      bit         waiting;
      exp_t       e;
      ns = m_state; nc = m_cause; nrd = 1'b0; nwr = 1'b0; waiting = 0;
      if (!s.resetn) begin
         ns = M_HALT; nc = 3'd0; m_cnt = '0; m_tmo = 0;
      end else begin
         case (m_state)
            M_HALT: if (s.go) begin ns = M_READ; nc = 3'd0; end
            M_READ: begin
               if (s.instr_segv) begin ns = M_TRAP; nc = 3'd1; end
               else if (s.wait_instr) begin
                  if (m_tmo == TMO_MAX) begin ns = M_TRAP; nc = 3'd4; end
                  else waiting = 1;
               end
               else if (s.invalid_instruction) begin ns = M_TRAP; nc = 3'd3; end
               else if (s.ld) begin ns = M_WL; nrd = 1'b1; end
               else if (s.st) begin ns = M_WS; nwr = 1'b1; end
               else if (s.instr_alu && s.alu_busy) ns = M_EW;
               else ns = M_DO;
            end
            M_WL, M_WS: begin
               if (s.data_segv) begin ns = M_TRAP; nc = 3'd2; end
               else if (s.wait_data) begin
                  if (m_tmo == TMO_MAX) begin ns = M_TRAP; nc = 3'd5; end
                  else waiting = 1;
               end
               else ns = M_DO;
            end
            M_EW: if (!s.alu_busy) ns = M_DO;
            M_DO: begin
               m_cnt = m_cnt + 1'b1;
               if (s.data_segv) begin ns = M_TRAP; nc = 3'd2; end
               else if (s.invalid_instruction) begin ns = M_TRAP; nc = 3'd3; end
               else if (s.halt) ns = M_HALT;
               else ns = M_READ;
            end
            M_TRAP: if (s.trap_ack) ns = M_HALT;
            default: ns = M_HALT;
         endcase
         m_tmo = (ns != m_state) ? 0 : (waiting ? m_tmo + 1 : m_tmo);
      end
      m_state = ns;
      m_cause = nc;
      e.state = ns; e.cause = nc; e.rd = nrd; e.wr = nwr; e.ret = (ns == M_DO); e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic checkCycle();
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("state", 32'(current_state), 32'(e.state));
      checkOutput("trap_cause", 32'(trap_cause), 32'(e.cause));
      checkOutput("mem_rd", 32'(mem_rd), 32'(e.rd));
      checkOutput("mem_wr", 32'(mem_wr), 32'(e.wr));
      checkOutput("retired", 32'(retired), 32'(e.ret));
      checkOutput("retired_count", 32'(retired_count), 32'(e.cnt));
   endtask

   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      {resetn, go, halt, instr_alu, instr_pc, ld, st, wait_instr, wait_data,
       alu_busy, instr_segv, data_segv, invalid_instruction, trap_ack} = s;
      modelStep(s);
      @(posedge clk);
      #1;
      checkCycle();
   endtask

   task automatic stepIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(idle());
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      stim_t s;
      {resetn, go, halt, instr_alu, instr_pc, ld, st, wait_instr, wait_data,
       alu_busy, instr_segv, data_segv, invalid_instruction, trap_ack} = '0;

      // reset held two cycles with go asserted
      s = idle(); s.resetn = 1'b0; s.go = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("reset_state", 32'(current_state), 32'h00);
      checkOutput("reset_cause", 32'(trap_cause), 32'h0);
      checkOutput("reset_count", 32'(retired_count), 32'h0);
      s = idle(); s.go = 1'b1;
      applyStimulus(s);
      checkOutput("release_read", 32'(current_state), 32'h08);

      // fetch stall then ALU op
      s = idle(); s.wait_instr = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(s);
      s = idle(); s.instr_alu = 1'b1;
      applyStimulus(s);
      checkOutput("alu_do", 32'(current_state), 32'h09);
      stepIdle(1);
      checkOutput("alu_count", 32'(retired_count), 32'h1);

      // load with two data waits, then store with none
      s = idle(); s.ld = 1'b1; applyStimulus(s);
      s = idle(); s.wait_data = 1'b1; applyStimulus(s); applyStimulus(s);
      stepIdle(2);
      s = idle(); s.st = 1'b1; applyStimulus(s);
      stepIdle(2);

      // data timeout
      s = idle(); s.ld = 1'b1; applyStimulus(s);
      s = idle(); s.wait_data = 1'b1;
      for (int i = 0; i < TMO_MAX + 1; i++) applyStimulus(s);
      checkOutput("dto_cause", 32'(trap_cause), 32'h5);
      stepIdle(1);
      s = idle(); s.trap_ack = 1'b1; applyStimulus(s);
      checkOutput("ack_keeps_cause", 32'(trap_cause), 32'h5);
      s = idle(); s.go = 1'b1; applyStimulus(s);
      checkOutput("go_clears_cause", 32'(trap_cause), 32'h0);

      // fetch timeout
      s = idle(); s.wait_instr = 1'b1;
      for (int i = 0; i < TMO_MAX + 1; i++) applyStimulus(s);
      checkOutput("fto_cause", 32'(trap_cause), 32'h4);
      s = idle(); s.trap_ack = 1'b1; applyStimulus(s);
      s = idle(); s.go = 1'b1; applyStimulus(s);

      // fault beats wait; load beats store
      s = idle(); s.instr_segv = 1'b1; s.wait_instr = 1'b1; applyStimulus(s);
      checkOutput("segv_cause", 32'(trap_cause), 32'h1);
      s = idle(); s.trap_ack = 1'b1; applyStimulus(s);
      s = idle(); s.go = 1'b1; applyStimulus(s);
      s = idle(); s.ld = 1'b1; s.st = 1'b1; applyStimulus(s);
      checkOutput("ld_wins", 32'(current_state), 32'h0a);
      s = idle(); s.data_segv = 1'b1; s.wait_data = 1'b1; applyStimulus(s);
      s = idle(); s.trap_ack = 1'b1; applyStimulus(s);
      s = idle(); s.go = 1'b1; applyStimulus(s);

      // invalid in fetch, then data fault in DO still retires
      s = idle(); s.invalid_instruction = 1'b1; applyStimulus(s);
      s = idle(); s.trap_ack = 1'b1; applyStimulus(s);
      s = idle(); s.go = 1'b1; applyStimulus(s);
      s = idle(); s.instr_pc = 1'b1; applyStimulus(s);
      s = idle(); s.data_segv = 1'b1; applyStimulus(s);
      s = idle(); s.trap_ack = 1'b1; applyStimulus(s);
      s = idle(); s.go = 1'b1; applyStimulus(s);

      // multi-cycle ALU, then halt in DO
      s = idle(); s.instr_alu = 1'b1; s.alu_busy = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(s);
      checkOutput("exec_wait", 32'(current_state), 32'h0b);
      stepIdle(1);
      s = idle(); s.halt = 1'b1; applyStimulus(s);
      checkOutput("halted", 32'(current_state), 32'h00);

      // reset mid-wait and in TRAP
      s = idle(); s.go = 1'b1; applyStimulus(s);
      s = idle(); s.ld = 1'b1; applyStimulus(s);
      s = idle(); s.wait_data = 1'b1; s.resetn = 1'b0; applyStimulus(s);
      s = idle(); s.go = 1'b1; applyStimulus(s);
      s = idle(); s.instr_segv = 1'b1; applyStimulus(s);
      s = idle(); s.resetn = 1'b0; applyStimulus(s);
      checkOutput("reset_in_trap", 32'(trap_cause), 32'h0);

      // illegal state code recovers to HALT
      s = idle(); s.go = 1'b1; applyStimulus(s);
      force dut.state_q = 5'b11111;
      #1;
      checkOutput("forced_state", 32'(current_state), 32'h1f);
      release dut.state_q;
      m_state = 5'b11111;
      stepIdle(1);
      checkOutput("illegal_recover", 32'(current_state), 32'h00);

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         s.resetn              = ($urandom_range(0, 31) != 0);
         s.go                  = ($urandom_range(0, 1) == 0);
         s.halt                = ($urandom_range(0, 3) == 0);
         s.instr_alu           = ($urandom_range(0, 2) == 0);
         s.instr_pc            = ($urandom_range(0, 3) == 0);
         s.ld                  = ($urandom_range(0, 3) == 0);
         s.st                  = ($urandom_range(0, 3) == 0);
         s.wait_instr          = ($urandom_range(0, 2) == 0);
         s.wait_data           = ($urandom_range(0, 1) == 0);
         s.alu_busy            = ($urandom_range(0, 1) == 0);
         s.instr_segv          = ($urandom_range(0, 15) == 0);
         s.data_segv           = ($urandom_range(0, 15) == 0);
         s.invalid_instruction = ($urandom_range(0, 15) == 0);
         s.trap_ack            = ($urandom_range(0, 3) == 0);
         applyStimulus(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_fsm_timed.md
Name: ctrl_fsm_timed

Overview:
- Next-generation processor control-path sequencer. Successor to the current halt/fetch/load/store/execute/trap controller.
- Adds synchronous active-low reset, multi-cycle ALU stalls and parametrised memory-wait timeouts.
- Adds a latched trap cause, registered memory strobes and a retired-instruction counter.
- Sits between the fetch/LSU/ALU handshakes and the datapath, which decodes current_state.

Parameters:
- TMO_W, 8, width of the memory-wait timeout counter.
- TMO_MAX, 255, wait cycles allowed before a timeout trap. Range 1..2^TMO_W-1.
- RET_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- go  in  1  start execution from HALT
- halt  in  1  current instruction is a halt (sampled in DO)
- instr_alu  in  1  decoded ALU instruction
- instr_pc  in  1  decoded branch/jump instruction
- ld  in  1  decoded load
- st  in  1  decoded store
- wait_instr  in  1  instruction memory not ready
- wait_data  in  1  data memory not ready
- alu_busy  in  1  multi-cycle ALU operation in progress
- instr_segv  in  1  fetch fault
- data_segv  in  1  data access fault
- invalid_instruction  in  1  decode fault
- trap_ack  in  1  software/debug acknowledges the trap
- current_state  out  5  state encoding
- trap_cause  out  3  latched trap reason
- mem_rd  out  1  data read strobe (registered)
- mem_wr  out  1  data write strobe (registered)
- retired  out  1  one-cycle pulse per retired instruction
- retired_count  out  RET_W  retired-instruction count

Behaviour:
- State encodings: HALT 5'b00000, READ_INS 5'b01000, DO 5'b01001, WAIT_LOAD 5'b01010, EXEC_WAIT 5'b01011, WAIT_STORE 5'b01100, TRAP 5'b10000. Any other code goes to HALT next cycle.
- Reset (resetn=0 at posedge): state=HALT, trap_cause=0, mem_rd=mem_wr=retired=0, retired_count=0, timeout counter=0. Reset overrides every other input, including mid-wait and in TRAP.
- HALT: go → READ_INS, else stay.
- READ_INS, checks in priority order:
  - instr_segv → TRAP, cause 1.
  - wait_instr → stay, increment counter; counter reaching TMO_MAX → TRAP, cause 4.
  - invalid_instruction → TRAP, cause 3.
  - ld → WAIT_LOAD. st → WAIT_STORE. Both ld and st set: ld wins.
  - instr_alu & alu_busy → EXEC_WAIT.
  - Otherwise (ALU, PC or no-op) → DO. No-op is explicit; no unassigned next state.
- WAIT_LOAD / WAIT_STORE, in order:
  - data_segv → TRAP, cause 2.
  - wait_data → stay, increment counter; counter reaching TMO_MAX → TRAP, cause 5.
  - Otherwise → DO.
  - mem_rd (load) or mem_wr (store) is high in the first cycle of the state only.
- EXEC_WAIT: alu_busy low → DO, else stay. No timeout.
- DO:
  - retired=1 for this cycle; retired_count increments, wrapping at 2^RET_W.
  - halt → HALT; otherwise → READ_INS.
  - data_segv or invalid_instruction in DO → TRAP, cause 2 or 3. The instruction still retires.
- TRAP: trap_cause holds its value. trap_ack → HALT with trap_cause unchanged. trap_cause clears on the next go from HALT.
- Timeout counter: TMO_W bits, cleared on every state change, saturates. Timeout is detected the cycle the counter equals TMO_MAX while the wait is still asserted. Total wait cycles before the trap transition = TMO_MAX+1.
- trap_cause codes: 0 none, 1 instr_segv, 2 data_segv, 3 invalid, 4 fetch timeout, 5 data timeout.
- Fault takes priority over wait in the same cycle.

Test Plan:
- Reset: resetn=0 for 2 cycles with go=1 → state 00000, trap_cause=0, retired_count=0. Release with go=1 → READ_INS next cycle.
- ALU flow: go, then wait_instr high 3 cycles, then instr_alu=1 → READ_INS×4, DO×1, retired pulse, retired_count=1, back to READ_INS.
- Load/store: ld with wait_data 2 cycles → WAIT_LOAD×3, mem_rd high 1 cycle, DO. Then st with no wait → WAIT_STORE×1, mem_wr pulse.
- Timeout: TMO_MAX=4, wait_data stuck high in WAIT_LOAD → TRAP after 5 cycles, trap_cause=5. trap_ack → HALT with cause 5. go → cause 0.
- Priority: READ_INS with instr_segv=1 and wait_instr=1 → TRAP with cause 1. ld=st=1 → WAIT_LOAD.
- Multi-cycle ALU and halt: instr_alu with alu_busy high 3 cycles → EXEC_WAIT×3, DO. halt=1 in DO → HALT. Illegal state forced to 5'b11111 → HALT next cycle.
